call_stack_param: RTL and testbench
===================================

Name: call_stack_param

Overview:
- Parametrised hardware return-address stack for the MCU core; successor to the fixed 11-bit × 16 call stack.
- Sits between the PC logic and the instruction decoder. CALL/interrupt entry drives push; RETURN/RETFIE drives pop.
- Adds over the fixed stack:
  - configurable width and depth
  - occupancy count, full and empty status
  - sticky overflow/underflow flags with clear
  - selectable wrap or saturate overflow policy
  - defined push+pop (replace-top) behaviour
  - indexed debug peek port

Parameters:
- WIDTH, 11, bits per entry (return address width).
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2.
- WRAP_MODE, 1: 1 = circular; overflow overwrites oldest, underflow still moves the pointer. 0 = saturate; illegal push/pop is ignored.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  push stack_in this cycle.
- pop  in  1  pop top entry this cycle.
- stack_in  in  WIDTH  data to push.
- stack_out  out  WIDTH  current top entry, combinational read of mem[stk_ptr].
- clr_flags  in  1  clears overflow and underflow.
- peek_idx  in  DEPTH_LOG2  depth below top to read; 0 = top.
- peek_out  out  WIDTH  mem[stk_ptr - peek_idx] (mod DEPTH), combinational.
- count  out  DEPTH_LOG2+1  valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set by a push while full.
- underflow  out  1  sticky; set by a pop while empty.

Behaviour:
- State: stk_ptr (DEPTH_LOG2 bits), count, overflow, underflow, and the memory array (not reset).
- Reset (highest priority): stk_ptr = DEPTH-1 (all ones), count = 0, overflow = 0, underflow = 0. Memory is unchanged. stack_out and peek_out are undefined until written.
- Pointer arithmetic is modulo DEPTH (natural DEPTH_LOG2-bit wrap). Write index = stk_ptr+1.
- Latency: a pushed value appears on stack_out the cycle after the push edge. A pop exposes the previous entry the cycle after the pop edge.
- Priority per cycle when not in reset (push, pop):
  - 1,0 not full: mem[stk_ptr+1] <= stack_in; stk_ptr++; count++.
  - 1,0 full, WRAP_MODE=1: write and stk_ptr++ (oldest entry overwritten); count stays DEPTH; overflow <= 1.
  - 1,0 full, WRAP_MODE=0: no write, no pointer change; overflow <= 1.
  - 0,1 not empty: stk_ptr--; count--.
  - 0,1 empty, WRAP_MODE=1: stk_ptr--; count stays 0; underflow <= 1.
  - 0,1 empty, WRAP_MODE=0: no change; underflow <= 1.
  - 1,1 not empty: replace top; mem[stk_ptr] <= stack_in; stk_ptr and count unchanged; no flag change, including when full.
  - 1,1 empty: treated as a plain push (count becomes 1); underflow <= 1.
- Flags: set and clear in the same cycle means set wins. clr_flags alone clears both on the next edge. Flags never self-clear.
- full, empty and count are registered-state derived (combinational from count), with no extra latency.
- Peek: peek_idx >= count returns stale memory contents. This is a debug-only port; no error is raised.

Test Plan:
- Reset, then push 0x123, 0x456, 0x7FF on consecutive cycles -> stack_out 0x123/0x456/0x7FF on the following cycles; count=3; peek_idx=2 gives 0x123; empty=0, full=0.
- Push 16 values 0x000..0x00F, then one more push 0x0AA, WRAP_MODE=1 -> full=1 after the 16th push; after the 17th, overflow=1, count=16, stack_out=0x0AA; 16 pops then yield 0x00F..0x001, then 0x0AA.
- Same sequence with WRAP_MODE=0 -> 17th push ignored: stack_out=0x00F, overflow=1, count=16.
- From reset, pop with WRAP_MODE=0 -> underflow=1, count=0, stk_ptr unchanged. Then assert clr_flags together with another empty pop -> underflow stays 1. Next clr_flags alone -> underflow=0.
- Push 0x100, 0x200, then push=pop=1 with stack_in=0x2FF -> count stays 2, stack_out=0x2FF; pop -> stack_out=0x100.
- Push 5 entries, assert reset during a push -> next cycle count=0, empty=1, flags 0. Push 0x055 -> stack_out=0x055, count=1.

Source files
------------

// File: rtl/call_stack_param.sv
// Return-address stack for the MCU core with configurable width and depth.
// It reports occupancy and keeps sticky overflow/underflow flags; a push while
// full either wraps or saturates, depending on WRAP_MODE.
module call_stack_param #(
   parameter int WIDTH      = 11,
   parameter int DEPTH_LOG2 = 4,
   parameter int WRAP_MODE  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      stack_in,
   output logic [WIDTH-1:0]      stack_out,
   input  logic                  clr_flags,
   input  logic [DEPTH_LOG2-1:0] peek_idx,
   output logic [WIDTH-1:0]      peek_out,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] stk_ptr, ptr_nxt, wr_idx;
   logic [DEPTH_LOG2:0]   cnt_nxt;
   logic                  wr_en, set_ovf, set_unf;

   assign stack_out = mem[stk_ptr];
   assign peek_out  = mem[stk_ptr - peek_idx];
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_CNT);

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = stk_ptr + 1'b1;
      ptr_nxt = stk_ptr;
      cnt_nxt = count;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      case ({push, pop})
         2'b10: begin
            if (!full) begin
               wr_en   = 1'b1;
               ptr_nxt = stk_ptr + 1'b1;
               cnt_nxt = count + 1'b1;
            end else begin
               set_ovf = 1'b1;
               // circular mode drops the oldest return address
               if (WRAP_MODE != 0) begin
                  wr_en   = 1'b1;
                  ptr_nxt = stk_ptr + 1'b1;
               end
            end
         end
         2'b01: begin
            if (!empty) begin
               ptr_nxt = stk_ptr - 1'b1;
               cnt_nxt = count - 1'b1;
            end else begin
               set_unf = 1'b1;
               if (WRAP_MODE != 0) ptr_nxt = stk_ptr - 1'b1;
            end
         end
         2'b11: begin
            if (!empty) begin
               wr_en  = 1'b1;
               wr_idx = stk_ptr;
            end else begin
               // nothing to replace: becomes a push, but the pop is reported
               wr_en   = 1'b1;
               ptr_nxt = stk_ptr + 1'b1;
               cnt_nxt = count + 1'b1;
               set_unf = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stk_ptr   <= '1;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         stk_ptr <= ptr_nxt;
         count   <= cnt_nxt;
         if (set_ovf)        overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;
         if (set_unf)        underflow <= 1'b1;
         else if (clr_flags) underflow <= 1'b0;
      end
   end

   // storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (!reset && wr_en) mem[wr_idx] <= stack_in;
   end

endmodule

// File: tb/tb_call_stack_param.sv
// Scoreboard bench: a wrap-mode and a saturate-mode stack share the same stimulus;
// the expected values are queued with each step and checked after its clock edge.
module tb_call_stack_param;

   localparam int W = 11;
   localparam int DL = 4;

   logic          clk = 1'b0;
   logic          reset, push, pop, clr_flags;
   logic [W-1:0]  stack_in;
   logic [DL-1:0] peek_idx;

   logic [W-1:0]  w_out, w_peek, s_out, s_peek;
   logic [DL:0]   w_cnt, s_cnt;
   logic          w_emp, w_full, w_ovf, w_unf, s_emp, s_full, s_ovf, s_unf;

   always #5 clk = ~clk;

   call_stack_param #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP_MODE(1)) u_wrap (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .stack_in(stack_in),
      .stack_out(w_out), .clr_flags(clr_flags), .peek_idx(peek_idx), .peek_out(w_peek),
      .count(w_cnt), .empty(w_emp), .full(w_full), .overflow(w_ovf), .underflow(w_unf));

   call_stack_param #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP_MODE(0)) u_sat (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .stack_in(stack_in),
      .stack_out(s_out), .clr_flags(clr_flags), .peek_idx(peek_idx), .peek_out(s_peek),
      .count(s_cnt), .empty(s_emp), .full(s_full), .overflow(s_ovf), .underflow(s_unf));

   // selectors: wrap instance 0..6, saturate instance 8..14
   localparam int SO = 0, CN = 1, FU = 2, EM = 3, OV = 4, UN = 5, PK = 6, S = 8;

   typedef struct {
      string tag;
      int    sel;
      int    val;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int obs(input int sel);
      case (sel)
         SO:     return int'(w_out);
         CN:     return int'(w_cnt);
         FU:     return int'(w_full);
         EM:     return int'(w_emp);
         OV:     return int'(w_ovf);
         UN:     return int'(w_unf);
         PK:     return int'(w_peek);
         S+SO:   return int'(s_out);
         S+CN:   return int'(s_cnt);
         S+FU:   return int'(s_full);
         S+EM:   return int'(s_emp);
         S+OV:   return int'(s_ovf);
         S+UN:   return int'(s_unf);
         S+PK:   return int'(s_peek);
         default: return -1;
      endcase
   endfunction

   task automatic ex(input string tag, input int sel, input int val);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = val;
      q.push_back(e);
   endtask

   // apply one cycle of stimulus, then score everything queued for it
   task automatic step(input logic ps, input logic pp, input int d,
                       input logic clr, input logic rst);
      exp_t e;
      push = ps; pop = pp; stack_in = W'(d); clr_flags = clr; reset = rst;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr_flags = 1'b0; reset = 1'b0;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk(e.tag, obs(e.sel), e.val);
      end
   endtask

   initial begin
      push = 0; pop = 0; clr_flags = 0; reset = 1; stack_in = '0; peek_idx = '0;
      @(negedge clk);

      // reset state and basic pushes
      ex("rst_cnt", CN, 0); ex("rst_empty", EM, 1); ex("rst_full", FU, 0);
      ex("rst_ovf", OV, 0); ex("rst_unf", UN, 0); ex("rst_sat_cnt", S+CN, 0);
      step(0, 0, 0, 0, 1);
      ex("push1_out", SO, 'h123);
      step(1, 0, 'h123, 0, 0);
      ex("push2_out", SO, 'h456);
      step(1, 0, 'h456, 0, 0);
      ex("push3_out", SO, 'h7FF); ex("push3_cnt", CN, 3);
      ex("push3_empty", EM, 0); ex("push3_full", FU, 0);
      step(1, 0, 'h7FF, 0, 0);
      peek_idx = 2;
      ex("peek2", PK, 'h123); ex("sat_peek2", S+PK, 'h123);
      step(0, 0, 0, 0, 0);
      peek_idx = 0;

      // fill to full, then one push past full in both policies
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         ex("fill_out", SO, i); ex("fill_cnt", CN, i + 1);
         if (i == 15) begin
            ex("fill_full", FU, 1); ex("fill_sat_full", S+FU, 1); ex("fill_ovf", OV, 0);
         end
         step(1, 0, i, 0, 0);
      end
      ex("wrap_ovf", OV, 1); ex("wrap_cnt", CN, 16); ex("wrap_out", SO, 'h0AA);
      ex("sat_ovf", S+OV, 1); ex("sat_cnt", S+CN, 16); ex("sat_out", S+SO, 'h00F);
      step(1, 0, 'h0AA, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         ex("drain_out", SO, (k < 16) ? 16 - k : 'h0AA);
         ex("drain_cnt", CN, 16 - k);
         ex("drain_sat_cnt", S+CN, 16 - k);
         step(0, 1, 0, 0, 0);
      end
      ex("drain_empty", EM, 1);
      step(0, 0, 0, 0, 0);

      // underflow, set-beats-clear, then clear
      step(0, 0, 0, 0, 1);
      ex("unf_sat", S+UN, 1); ex("unf_sat_cnt", S+CN, 0); ex("unf_sat_empty", S+EM, 1);
      ex("unf_wrap", UN, 1); ex("unf_wrap_cnt", CN, 0);
      step(0, 1, 0, 0, 0);
      ex("unf_setwins_sat", S+UN, 1); ex("unf_setwins_wrap", UN, 1);
      step(0, 1, 0, 1, 0);
      ex("unf_clr_sat", S+UN, 0); ex("unf_clr_wrap", UN, 0);
      step(0, 0, 0, 1, 0);
      // stale memory below the new top reveals where each pointer landed
      peek_idx = 1;
      ex("post_unf_sat_out", S+SO, 'h0AB); ex("post_unf_sat_cnt", S+CN, 1);
      ex("post_unf_sat_peek", S+PK, 'h00F);
      ex("post_unf_wrap_out", SO, 'h0AB); ex("post_unf_wrap_peek", PK, 'h00D);
      step(1, 0, 'h0AB, 0, 0);
      peek_idx = 0;

      // replace-top
      step(0, 0, 0, 0, 1);
      step(1, 0, 'h100, 0, 0);
      step(1, 0, 'h200, 0, 0);
      ex("repl_cnt", CN, 2); ex("repl_out", SO, 'h2FF); ex("repl_unf", UN, 0);
      ex("repl_sat_out", S+SO, 'h2FF);
      step(1, 1, 'h2FF, 0, 0);
      ex("repl_pop_out", SO, 'h100); ex("repl_pop_cnt", CN, 1);
      step(0, 1, 0, 0, 0);

      // push+pop on empty behaves as a push and flags underflow
      step(0, 0, 0, 0, 1);
      ex("pp_empty_cnt", CN, 1); ex("pp_empty_out", SO, 'h321);
      ex("pp_empty_unf", UN, 1); ex("pp_empty_sat_unf", S+UN, 1); ex("pp_empty_ovf", OV, 0);
      step(1, 1, 'h321, 0, 0);

      // reset during a push wins
      for (int i = 0; i < 5; i++) step(1, 0, 'h010 + i, 0, 0);
      ex("rpush_cnt_pre", CN, 6);
      step(0, 0, 0, 0, 0);
      ex("rpush_cnt", CN, 0); ex("rpush_empty", EM, 1);
      ex("rpush_ovf", OV, 0); ex("rpush_unf", UN, 0); ex("rpush_sat_unf", S+UN, 0);
      step(1, 0, 'h03C, 0, 1);
      ex("after_rst_out", SO, 'h055); ex("after_rst_cnt", CN, 1);
      step(1, 0, 'h055, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
